truth_table_sweep: RTL and testbench
====================================

// Module: truth_table_sweep
// PURPOSE
//   Self-running exhaustive stimulus generator and response capturer for
//   N-input combinational exercise blocks. On start it drives all 2^N_IN input
//   vectors to the unit under test, holds each for HOLD cycles and samples the
//   1-bit response. It records the full truth table and a minterm count.
//   It replaces hand-written for-loop benches and can run on the board.
// PARAMETERS
//   N_IN  4  number of DUT inputs (1..8); vector index width
//   HOLD  1  clk cycles each vector is held before sampling (>=1)
//   GRAY  0  0: binary order 0,1,2,...; 1: Gray order (idx ^ idx>>1)
// PORTS
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        synchronous reset, active low
//   start      in   1        1-cycle pulse; begins a sweep from IDLE or DONE
//   abort      in   1        stop the sweep, return to IDLE
//   dut_out    in   1        DUT response to vec_out
//   vec_out    out  N_IN     vector driven to DUT, MSB = input A
//   busy       out  1        sweep in progress
//   done       out  1        sweep complete; held until next start/abort/reset
//   table_out  out  2^N_IN   captured truth table; bit v = f(vector v)
//   ones_cnt   out  N_IN+1   number of minterms (1s) captured this sweep
// BEHAVIOUR
//   States: IDLE, DRIVE, DONE. Registers: idx[N_IN-1:0], hold_cnt, table, ones.
//   Reset (rst_n=0 at edge): state=IDLE, idx=0, hold_cnt=0, table=0, ones=0.
//     vec_out=0, busy=0, done=0. Reset has priority over abort and start.
//   vec_out = GRAY ? idx^(idx>>1) : idx. It is a function of registered idx only.
//   IDLE/DONE + start: idx<=0, hold_cnt<=0, table<=0, ones<=0, ->DRIVE.
//     busy=1 and done=0 from the next cycle.
//   DRIVE, each edge:
//     - hold_cnt<HOLD-1: hold_cnt++.
//     - hold_cnt==HOLD-1: table[vec_out]<=dut_out, ones<=ones+dut_out.
//       If idx==2^N_IN-1, go to DONE; otherwise idx++ and hold_cnt<=0.
//   Each vector is visible for exactly HOLD cycles. dut_out is sampled on the
//     last edge of that window. The sweep lasts HOLD*2^N_IN cycles.
//   DONE: busy=0, done=1. table, ones and vec_out (last vector) are frozen.
//   start while in DRIVE is ignored. The sweep is not restarted.
//   abort in any state: ->IDLE, busy=0, done=0. idx, table and ones keep
//     their partial values. abort wins over start on the same edge.
//   Widths: ones_cnt is N_IN+1 bits, so it holds 2^N_IN without overflow.
//     idx does not wrap; the last-index compare ends the sweep first.
//     hold_cnt is $clog2(HOLD+1) bits.
//   GRAY changes only the visiting order. table_out is indexed by vector value,
//     so both orders give an identical table for the same function.
// TESTING
//   1 N_IN=4,HOLD=1,GRAY=0; dut_out=vec_out[3]&vec_out[0]; start.
//     -> vec_out 0..15, one per cycle; done after 16 cycles;
//     table_out=16'hAA00; ones_cnt=4.
//   2 GRAY=1, same function. -> vec_out sequence 0,1,3,2,6,7,5,4,12,...,8;
//     table_out=16'hAA00; ones_cnt=4.
//   3 HOLD=3; dut_out=^vec_out (parity). -> each vector stable 3 cycles;
//     done at cycle 48; table_out=16'h6996; ones_cnt=8.
//   4 Pulse start during cycle 5 of a sweep. -> idx not reset, sequence
//     continues, done still at cycle 16. abort at cycle 7 -> IDLE, busy=0,
//     done=0, table_out retains bits for vectors 0..6.
//   5 rst_n=0 mid-sweep (idx=9). -> next edge: all outputs 0, state IDLE.
//     start afterwards gives a full clean sweep with correct table.
//   6 N_IN=1, dut_out=~vec_out[0]. -> table_out=2'b01, ones_cnt=1,
//     done after 2 cycles. start in DONE re-runs with the same result.

Source files
------------

// File: rtl/truth_table_sweep_if.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweep_if
//  Description : Control, stimulus and capture bundle of the truth-table sweeper.
//  Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_sweep_if #(
    parameter int N_IN = 4
);
    localparam int c_NVEC = 2 ** N_IN;

    logic              start;
    logic              abort;
    logic              dut_out;
    logic [N_IN-1:0]   vec_out;
    logic              busy;
    logic              done;
    logic [c_NVEC-1:0] table_out;
    logic [N_IN:0]     ones_cnt;

    // master = sweeper, slave = the environment that starts it and hosts the unit under test
    modport master (
        input  start, abort, dut_out,
        output vec_out, busy, done, table_out, ones_cnt
    );
    modport slave (
        output start, abort, dut_out,
        input  vec_out, busy, done, table_out, ones_cnt
    );
endinterface
`default_nettype wire

// File: rtl/truth_table_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweep
//  Description : Exhaustive 2^N_IN vector sweeper that captures a 1-bit truth table.
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweep #(
    parameter int N_IN = 4,
    parameter int HOLD = 1,
    parameter int GRAY = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    truth_table_sweep_if.master bus
);
    localparam int              c_NVEC      = 2 ** N_IN;
    localparam int              c_HW        = $clog2(HOLD + 1);
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD - 1);
    localparam logic [N_IN-1:0] c_IDX_LAST  = {N_IN{1'b1}};

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRIVE = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]        r_state, w_state_nxt;
    logic [N_IN-1:0]   r_idx, w_idx_nxt;
    logic [c_HW-1:0]   r_hold, w_hold_nxt;
    logic [c_NVEC-1:0] r_table, w_table_nxt;
    logic [N_IN:0]     r_ones, w_ones_nxt;
    logic [N_IN-1:0]   w_vec;

    // The table is indexed by vector value, so visiting order never affects its content
    generate
        if (GRAY != 0) begin : g_gray
            assign w_vec = r_idx ^ (r_idx >> 1);
        end else begin : g_binary
            assign w_vec = r_idx;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
            r_table <= '0;
            r_ones  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_hold  <= w_hold_nxt;
            r_table <= w_table_nxt;
            r_ones  <= w_ones_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_hold_nxt  = r_hold;
        w_table_nxt = r_table;
        w_ones_nxt  = r_ones;
        // abort leaves idx, table and ones holding their partial results
        if (bus.abort) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (bus.start) begin
                        w_state_nxt = c_ST_DRIVE;
                        w_idx_nxt   = '0;
                        w_hold_nxt  = '0;
                        w_table_nxt = '0;
                        w_ones_nxt  = '0;
                    end
                end
                c_ST_DRIVE: begin
                    if (r_hold == c_HOLD_LAST) begin
                        w_table_nxt[w_vec] = bus.dut_out;
                        w_ones_nxt         = r_ones + {{N_IN{1'b0}}, bus.dut_out};
                        if (r_idx == c_IDX_LAST) begin
                            w_state_nxt = c_ST_DONE;
                        end else begin
                            w_idx_nxt  = r_idx + 1'b1;
                            w_hold_nxt = '0;
                        end
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    assign bus.vec_out   = w_vec;
    assign bus.busy      = (r_state == c_ST_DRIVE);
    assign bus.done      = (r_state == c_ST_DONE);
    assign bus.table_out = r_table;
    assign bus.ones_cnt  = r_ones;
endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_sweep
//  Description : Self-checking bench for four sweeper configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweep;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  start, abort;
    int          sel [4];
    logic [15:0] rt;

    int pn [4] = '{4, 4, 4, 1};
    int ph [4] = '{1, 1, 3, 1};
    int pg [4] = '{0, 1, 0, 0};

    int checks   = 0;
    int failures = 0;

    // reference model state, one slot per instance
    bit          m_run  [4];
    bit          m_done [4];
    int          m_t    [4];
    logic [15:0] m_tbl  [4];
    int          m_ones [4];

    always #5 clk = ~clk;

    function automatic logic fval(input int s, input logic [7:0] v, input logic [15:0] t);
        case (s)
            0:       return v[3] & v[0];
            1:       return ^v;
            2:       return ~v[0];
            default: return t[v[3:0]];
        endcase
    endfunction

    truth_table_sweep_if #(.N_IN(4)) if0 ();
    truth_table_sweep_if #(.N_IN(4)) if1 ();
    truth_table_sweep_if #(.N_IN(4)) if2 ();
    truth_table_sweep_if #(.N_IN(1)) if3 ();

    truth_table_sweep #(.N_IN(4), .HOLD(1), .GRAY(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    truth_table_sweep #(.N_IN(4), .HOLD(1), .GRAY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    truth_table_sweep #(.N_IN(4), .HOLD(3), .GRAY(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    truth_table_sweep #(.N_IN(1), .HOLD(1), .GRAY(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if0.start = start[0]; assign if0.abort = abort[0];
    assign if1.start = start[1]; assign if1.abort = abort[1];
    assign if2.start = start[2]; assign if2.abort = abort[2];
    assign if3.start = start[3]; assign if3.abort = abort[3];
    assign if0.dut_out = fval(sel[0], 8'(if0.vec_out), rt);
    assign if1.dut_out = fval(sel[1], 8'(if1.vec_out), rt);
    assign if2.dut_out = fval(sel[2], 8'(if2.vec_out), rt);
    assign if3.dut_out = fval(sel[3], 8'(if3.vec_out), rt);

    logic [7:0]  vo [4];
    logic        bz [4];
    logic        dn [4];
    logic [15:0] tt [4];
    logic [7:0]  oc [4];
    assign vo[0] = 8'(if0.vec_out); assign bz[0] = if0.busy; assign dn[0] = if0.done;
    assign vo[1] = 8'(if1.vec_out); assign bz[1] = if1.busy; assign dn[1] = if1.done;
    assign vo[2] = 8'(if2.vec_out); assign bz[2] = if2.busy; assign dn[2] = if2.done;
    assign vo[3] = 8'(if3.vec_out); assign bz[3] = if3.busy; assign dn[3] = if3.done;
    assign tt[0] = 16'(if0.table_out); assign oc[0] = 8'(if0.ones_cnt);
    assign tt[1] = 16'(if1.table_out); assign oc[1] = 8'(if1.ones_cnt);
    assign tt[2] = 16'(if2.table_out); assign oc[2] = 8'(if2.ones_cnt);
    assign tt[3] = 16'(if3.table_out); assign oc[3] = 8'(if3.ones_cnt);

    task automatic check(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", name, inst, got, exp, $time);
        end
    endtask

    // k-th visited vector: position in the sweep mapped through the visiting order
    function automatic int ord(input int i, input int k);
        return (pg[i] != 0) ? (k ^ (k >> 1)) : k;
    endfunction

    function automatic int exp_vec(input int i);
        int k;
        k = m_t[i] / ph[i];
        if (k > (1 << pn[i]) - 1) k = (1 << pn[i]) - 1;
        return ord(i, k);
    endfunction

    task automatic model_update();
        int k, v;
        logic b;
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                m_run[i] = 0; m_done[i] = 0; m_t[i] = 0; m_tbl[i] = '0; m_ones[i] = 0;
            end else if (abort[i]) begin
                m_run[i] = 0; m_done[i] = 0;
            end else if (!m_run[i] && start[i]) begin
                m_run[i] = 1; m_done[i] = 0; m_t[i] = 0; m_tbl[i] = '0; m_ones[i] = 0;
            end else if (m_run[i]) begin
                k = m_t[i] / ph[i];
                if (m_t[i] % ph[i] == ph[i] - 1) begin
                    v = ord(i, k);
                    b = fval(sel[i], 8'(v), rt);
                    m_tbl[i][v] = b;
                    m_ones[i] += int'(b);
                    if (k == (1 << pn[i]) - 1) begin
                        m_run[i] = 0; m_done[i] = 1;
                    end
                end
                m_t[i]++;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            check("vec_out", i, 32'(vo[i]), 32'(exp_vec(i)));
            check("busy", i, 32'(bz[i]), 32'(m_run[i]));
            check("done", i, 32'(dn[i]), 32'(m_done[i]));
            check("table_out", i, 32'(tt[i]), 32'(m_tbl[i]));
            check("ones_cnt", i, 32'(oc[i]), 32'(m_ones[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    // pulse start, then count edges until done (bounded)
    task automatic run_sweep(input int i, input int s, output int n);
        sel[i] = s;
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
        n = 0;
        while (!dn[i] && n < 200) begin
            step();
            n++;
        end
    endtask

    typedef struct {
        int          inst;
        int          s;
        logic [15:0] tbl;
        int          ones;
        int          cyc;
    } vec_t;

    vec_t vt [6];
    int   gseq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    initial begin
        int n;
        vt[0] = '{inst: 0, s: 0, tbl: 16'hAA00, ones: 4, cyc: 16};
        vt[1] = '{inst: 1, s: 0, tbl: 16'hAA00, ones: 4, cyc: 16};
        vt[2] = '{inst: 2, s: 1, tbl: 16'h6996, ones: 8, cyc: 48};
        vt[3] = '{inst: 3, s: 2, tbl: 16'h0001, ones: 1, cyc: 2};
        vt[4] = '{inst: 3, s: 2, tbl: 16'h0001, ones: 1, cyc: 2};
        vt[5] = '{inst: 1, s: 1, tbl: 16'h6996, ones: 8, cyc: 16};

        rst_n = 1'b0; start = '0; abort = '0; rt = '0;
        for (int i = 0; i < 4; i++) begin
            sel[i] = 0; m_run[i] = 0; m_done[i] = 0; m_t[i] = 0; m_tbl[i] = '0; m_ones[i] = 0;
        end
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int r = 0; r < 6; r++) begin
            run_sweep(vt[r].inst, vt[r].s, n);
            check("sweep_cycles", vt[r].inst, 32'(n), 32'(vt[r].cyc));
            check("sweep_table", vt[r].inst, 32'(tt[vt[r].inst]), 32'(vt[r].tbl));
            check("sweep_ones", vt[r].inst, 32'(oc[vt[r].inst]), 32'(vt[r].ones));
        end

        // Gray visiting order observed directly
        sel[1] = 0;
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("gray_seq", 1, 32'(vo[1]), 32'(gseq[k]));
            step();
        end

        // start inside a sweep is ignored
        sel[0] = 0;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int k = 0; k < 4; k++) step();
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        n = 5;
        while (!dn[0] && n < 200) begin
            step();
            n++;
        end
        check("restart_ignored_cycles", 0, 32'(n), 32'd16);
        check("restart_ignored_table", 0, 32'(tt[0]), 32'h0000AA00);

        // abort after vectors 0..6 captured keeps the partial table
        sel[0] = 1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int k = 0; k < 7; k++) step();
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        check("abort_busy", 0, 32'(bz[0]), 32'd0);
        check("abort_done", 0, 32'(dn[0]), 32'd0);
        check("abort_table", 0, 32'(tt[0]), 32'h00000016);
        check("abort_ones", 0, 32'(oc[0]), 32'd3);

        // reset at idx 9 clears everything, then a clean sweep follows
        rt = 16'hC35A;
        sel[0] = 3;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int k = 0; k < 9; k++) step();
        check("pre_reset_vec", 0, 32'(vo[0]), 32'd9);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("reset_vec", 0, 32'(vo[0]), 32'd0);
        check("reset_busy", 0, 32'(bz[0]), 32'd0);
        check("reset_table", 0, 32'(tt[0]), 32'd0);
        check("reset_ones", 0, 32'(oc[0]), 32'd0);
        run_sweep(0, 3, n);
        check("post_reset_cycles", 0, 32'(n), 32'd16);
        check("post_reset_table", 0, 32'(tt[0]), 32'h0000C35A);
        check("post_reset_ones", 0, 32'(oc[0]), 32'(8));

        // random traffic on all instances against the model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                start[i] = ($urandom_range(0, 15) == 0);
                abort[i] = ($urandom_range(0, 63) == 0);
                if ($urandom_range(0, 31) == 0) sel[i] = int'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 99) == 0) rt = 16'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        start = '0; abort = '0; rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
